// File: rtl/ddr_pkg.sv
// Shared DDR4 command/address definitions.
//   command_type : decoded command on the CA bus
//   bank_state_t : per-bank protocol state
//   dec_err_t    : decoder protocol error cause
package ddr_pkg;

  typedef enum logic [3:0] {
    DES, NOP, ACT, MRS, REF, PRE, PREA, WR, WRA, RD, RDA, ZQCL, ILLEGAL
  } command_type;

  typedef enum logic [1:0] {
    IDLE, ACTIVATING, ACTIVE, PRECHARGING
  } bank_state_t;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_ILLEGAL, ERR_TRFC, ERR_ACT_OPEN, ERR_NOT_OPEN, ERR_TRCD, ERR_REF_OPEN
  } dec_err_t;

  localparam int unsigned NUM_BANKS = 16;

endpackage

// File: rtl/dimm_bank_fsm.sv
// One DRAM bank: protocol state, tRCD/tRP countdown and the open row.
//   clk_i, rst_ni   : clock, async active-low reset
//   act_i           : accepted ACT to this bank (row_i captured)
//   pre_i           : accepted PRE to this bank or PREA
//   auto_pre_i      : accepted RDA/WRA to this bank
//   state_eff_o     : state as seen by a command sampled on this edge
//   state_o, row_o  : registered state and stored row
module dimm_bank_fsm
  import ddr_pkg::*;
#(
  parameter int unsigned T_RCD = 11,
  parameter int unsigned T_RP  = 11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        act_i,
  input  logic        pre_i,
  input  logic        auto_pre_i,
  input  logic [13:0] row_i,
  output bank_state_t state_eff_o,
  output bank_state_t state_o,
  output logic [13:0] row_o
);

  localparam int unsigned TMax = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned CntW = (TMax > 0) ? $clog2(TMax + 1) : 1;

  bank_state_t     state_q, state_d, state_eff;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [13:0]     row_q, row_d;
  logic            expiring;

  // A count of 1 reaches 0 on this edge; the command sampled now already sees
  // the post-expiry state.
  always_comb begin
    expiring  = (cnt_q <= CntW'(1));
    state_eff = state_q;
    if (state_q == ACTIVATING && expiring) state_eff = ACTIVE;
    if (state_q == PRECHARGING && expiring) state_eff = IDLE;
  end

  always_comb begin
    state_d = state_eff;
    cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
    row_d   = row_q;
    case (state_eff)
      IDLE: begin
        if (act_i) begin
          state_d = ACTIVATING;
          cnt_d   = CntW'(T_RCD);
          row_d   = row_i;
        end
      end
      ACTIVATING, ACTIVE: begin
        if (pre_i || (auto_pre_i && state_eff == ACTIVE)) begin
          state_d = PRECHARGING;
          cnt_d   = CntW'(T_RP);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  assign state_eff_o = state_eff;
  assign state_o     = state_q;
  assign row_o       = row_q;

endmodule

// File: rtl/dimm_cmd_decode.sv
// DDR4 DRAM-side command decoder and protocol checker.
//   CK_c, reset_n                : clock, async active-low reset
//   cs_n..WE_n_A14, bg/ba, A*    : command/address pins, sampled on rising CK_c
//   cmd_valid, cmd               : registered decoded command (non-DES/NOP)
//   bg, ba, row, col             : decoded address fields (row from bank on RD/WR)
//   mr_sel, mr_op                : MRS register select and opcode
//   bank_open                    : per-bank ACTIVATING/ACTIVE, index {bg,ba}
//   err, err_code                : one-cycle protocol error pulse and cause
module dimm_cmd_decode
  import ddr_pkg::*;
#(
  parameter int unsigned T_RCD = 11,
  parameter int unsigned T_RP  = 11,
  parameter int unsigned T_RFC = 280
) (
  input  logic        CK_c,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic        RAS_n_A16,
  input  logic        CAS_n_A15,
  input  logic        WE_n_A14,
  input  logic [1:0]  bg_addr,
  input  logic [1:0]  ba_addr,
  input  logic        A17,
  input  logic        A13,
  input  logic        A12_BC_n,
  input  logic        A11,
  input  logic        A10_AP,
  input  logic [9:0]  A9_A0,
  output logic        cmd_valid,
  output command_type cmd,
  output logic [1:0]  bg,
  output logic [1:0]  ba,
  output logic [13:0] row,
  output logic [9:0]  col,
  output logic [2:0]  mr_sel,
  output logic [17:0] mr_op,
  output logic [15:0] bank_open,
  output logic        err,
  output dec_err_t    err_code
);

  localparam int unsigned RfcW = (T_RFC > 0) ? $clog2(T_RFC + 1) : 1;

  command_type     dec_cmd;
  dec_err_t        dec_err;
  logic [3:0]      idx;
  logic [13:0]     pin_row;
  logic            is_rdwr, any_open, any_prech, rfc_busy;
  logic [15:0]     act_v, pre_v, ap_v;
  logic [RfcW-1:0] rfc_q, rfc_d;

  bank_state_t     bank_eff [NUM_BANKS];
  bank_state_t     bank_st  [NUM_BANKS];
  logic [13:0]     bank_row [NUM_BANKS];

  assign idx     = {bg_addr, ba_addr};
  assign pin_row = {A13, A12_BC_n, A11, A10_AP, A9_A0};

  always_comb begin
    dec_cmd = DES;
    if (cs_n) begin
      dec_cmd = DES;
    end else if (!act_n) begin
      dec_cmd = ACT;
    end else begin
      case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
        3'b000:  dec_cmd = MRS;
        3'b001:  dec_cmd = REF;
        3'b010:  dec_cmd = A10_AP ? PREA : PRE;
        3'b011:  dec_cmd = ILLEGAL;
        3'b100:  dec_cmd = A10_AP ? WRA : WR;
        3'b101:  dec_cmd = A10_AP ? RDA : RD;
        3'b110:  dec_cmd = A10_AP ? ZQCL : ILLEGAL;
        default: dec_cmd = NOP;
      endcase
    end
  end

  assign is_rdwr = (dec_cmd == RD) || (dec_cmd == WR) || (dec_cmd == RDA) || (dec_cmd == WRA);
  // Mirrors bank expiry: a count of 1 clears on this edge.
  assign rfc_busy = (rfc_q > RfcW'(1));

  always_comb begin
    any_open  = 1'b0;
    any_prech = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_eff[i] == ACTIVATING || bank_eff[i] == ACTIVE) any_open = 1'b1;
      if (bank_eff[i] == PRECHARGING) any_prech = 1'b1;
    end
  end

  always_comb begin
    dec_err = ERR_NONE;
    if (dec_cmd == ILLEGAL) begin
      dec_err = ERR_ILLEGAL;
    end else if (dec_cmd != DES && dec_cmd != NOP && rfc_busy) begin
      dec_err = ERR_TRFC;
    end else if (dec_cmd == ACT) begin
      if (bank_eff[idx] != IDLE) dec_err = ERR_ACT_OPEN;
    end else if (is_rdwr) begin
      if (bank_eff[idx] == ACTIVATING) dec_err = ERR_TRCD;
      else if (bank_eff[idx] != ACTIVE) dec_err = ERR_NOT_OPEN;
    end else if (dec_cmd == REF) begin
      if (any_open || any_prech) dec_err = ERR_REF_OPEN;
    end
  end

  // Erroring commands are reported but must not disturb bank state.
  always_comb begin
    act_v = '0;
    pre_v = '0;
    ap_v  = '0;
    if (dec_err == ERR_NONE) begin
      if (dec_cmd == ACT) act_v[idx] = 1'b1;
      if (dec_cmd == PRE) pre_v[idx] = 1'b1;
      if (dec_cmd == PREA) pre_v = '1;
      if (dec_cmd == RDA || dec_cmd == WRA) ap_v[idx] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    dimm_bank_fsm #(
      .T_RCD(T_RCD),
      .T_RP (T_RP)
    ) u_bank (
      .clk_i      (CK_c),
      .rst_ni     (reset_n),
      .act_i      (act_v[g]),
      .pre_i      (pre_v[g]),
      .auto_pre_i (ap_v[g]),
      .row_i      (pin_row),
      .state_eff_o(bank_eff[g]),
      .state_o    (bank_st[g]),
      .row_o      (bank_row[g])
    );
    assign bank_open[g] = (bank_st[g] == ACTIVATING) || (bank_st[g] == ACTIVE);
  end

  always_comb begin
    rfc_d = (rfc_q != '0) ? rfc_q - RfcW'(1) : '0;
    if (dec_cmd == REF && dec_err == ERR_NONE) rfc_d = RfcW'(T_RFC);
  end

  always_ff @(posedge CK_c or negedge reset_n) begin
    if (!reset_n) begin
      rfc_q     <= '0;
      cmd_valid <= 1'b0;
      cmd       <= DES;
      bg        <= '0;
      ba        <= '0;
      row       <= '0;
      col       <= '0;
      mr_sel    <= '0;
      mr_op     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      rfc_q     <= rfc_d;
      cmd_valid <= (dec_cmd != DES) && (dec_cmd != NOP);
      cmd       <= dec_cmd;
      bg        <= (dec_cmd != DES && dec_cmd != NOP) ? bg_addr : '0;
      ba        <= (dec_cmd != DES && dec_cmd != NOP) ? ba_addr : '0;
      row       <= (dec_cmd == ACT) ? pin_row : (is_rdwr ? bank_row[idx] : '0);
      col       <= is_rdwr ? A9_A0 : '0;
      mr_sel    <= (dec_cmd == MRS) ? {bg_addr[0], ba_addr} : '0;
      mr_op     <= (dec_cmd == MRS) ? {A17, RAS_n_A16, CAS_n_A15, WE_n_A14, pin_row} : '0;
      err       <= (dec_err != ERR_NONE);
      err_code  <= dec_err;
    end
  end

endmodule
